// File: rtl/mem_arbiter.sv
// Two-requester memory arbiter: bounded-burst fair arbitration onto a single
// synchronous-read memory port, with per-requester read-valid flags.
module mem_arbiter #(
  parameter int MAX_BURST = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req0,
  input  logic        req1,
  input  logic [31:0] addr0,
  input  logic [31:0] addr1,
  input  logic [31:0] wdata0,
  input  logic [31:0] wdata1,
  input  logic [3:0]  we0,
  input  logic [3:0]  we1,
  output logic        gnt0,
  output logic        gnt1,
  output logic        rvalid0,
  output logic        rvalid1,
  output logic [31:0] rdata0,
  output logic [31:0] rdata1,
  output logic        men,
  output logic [31:0] maddr,
  output logic [31:0] mwdata,
  output logic [3:0]  mwe,
  input  logic [31:0] mrdata,
  output logic [1:0]  dbg_state
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    OWN0 = 2'd1,
    OWN1 = 2'd2
  } state_t;

  localparam logic [3:0] MAX_BURST_C = 4'(MAX_BURST);

  state_t     state, state_n;
  logic [3:0] cnt, cnt_n, cnt_inc;
  logic       last_owner, last_owner_n;

  // Handshake: an access is transferred in any cycle where reqN && gntN.
  // The grant is purely combinational, so requesters hold their fields
  // stable until they see it.

  assign cnt_inc   = (cnt == 4'hF) ? cnt : cnt + 4'd1;
  assign dbg_state = state;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= IDLE;
      cnt        <= 4'd0;
      last_owner <= 1'b1;
      rvalid0    <= 1'b0;
      rvalid1    <= 1'b0;
    end else begin
      state      <= state_n;
      cnt        <= cnt_n;
      last_owner <= last_owner_n;
      rvalid0    <= gnt0 && (we0 == 4'b0000);
      rvalid1    <= gnt1 && (we1 == 4'b0000);
    end
  end

  always_comb begin
    state_n      = state;
    cnt_n        = cnt;
    last_owner_n = last_owner;
    gnt0         = 1'b0;
    gnt1         = 1'b0;
    if (reset) begin
      case (state)
        IDLE: begin
          // On a tie the requester that did not own the bus last goes first.
          if (req0 && (!req1 || last_owner)) begin
            gnt0 = 1'b1; state_n = OWN0; cnt_n = 4'd1; last_owner_n = 1'b0;
          end else if (req1) begin
            gnt1 = 1'b1; state_n = OWN1; cnt_n = 4'd1; last_owner_n = 1'b1;
          end
        end
        OWN0: begin
          if (req0 && (cnt < MAX_BURST_C || !req1)) begin
            gnt0 = 1'b1; cnt_n = cnt_inc;
          end else if (req1) begin
            gnt1 = 1'b1; state_n = OWN1; cnt_n = 4'd1; last_owner_n = 1'b1;
          end else begin
            state_n = IDLE; cnt_n = 4'd0;
          end
        end
        OWN1: begin
          if (req1 && (cnt < MAX_BURST_C || !req0)) begin
            gnt1 = 1'b1; cnt_n = cnt_inc;
          end else if (req0) begin
            gnt0 = 1'b1; state_n = OWN0; cnt_n = 4'd1; last_owner_n = 1'b0;
          end else begin
            state_n = IDLE; cnt_n = 4'd0;
          end
        end
        default: begin
          state_n = IDLE; cnt_n = 4'd0;
        end
      endcase
    end
  end

  always_comb begin
    men    = gnt0 | gnt1;
    maddr  = 32'd0;
    mwdata = 32'd0;
    mwe    = 4'b0000;
    if (gnt0) begin
      maddr = addr0; mwdata = wdata0; mwe = we0;
    end else if (gnt1) begin
      maddr = addr1; mwdata = wdata1; mwe = we1;
    end
  end

  assign rdata0 = mrdata;
  assign rdata1 = mrdata;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed table-driven bench for mem_arbiter (MAX_BURST=4) with a read-data
// scoreboard and hand-written reset sequences.
module tb_mem_arbiter;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_OWN0 = 2'd1;
  localparam logic [1:0] S_OWN1 = 2'd2;

  logic        clk, reset;
  logic        req0, req1;
  logic [31:0] addr0, addr1, wdata0, wdata1;
  logic [3:0]  we0, we1;
  logic        gnt0, gnt1, rvalid0, rvalid1;
  logic [31:0] rdata0, rdata1;
  logic        men;
  logic [31:0] maddr, mwdata;
  logic [3:0]  mwe;
  logic [31:0] mrdata;
  logic [1:0]  dbg_state;

  int n_pass  = 0;
  int n_total = 0;

  // expected read responses: {requester, data}
  logic [32:0] exp_q[$];

  mem_arbiter #(.MAX_BURST(4)) dut (
    .clk(clk), .reset(reset),
    .req0(req0), .req1(req1),
    .addr0(addr0), .addr1(addr1),
    .wdata0(wdata0), .wdata1(wdata1),
    .we0(we0), .we1(we1),
    .gnt0(gnt0), .gnt1(gnt1),
    .rvalid0(rvalid0), .rvalid1(rvalid1),
    .rdata0(rdata0), .rdata1(rdata1),
    .men(men), .maddr(maddr), .mwdata(mwdata), .mwe(mwe),
    .mrdata(mrdata), .dbg_state(dbg_state)
  );

  // clock/reset block
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // memory model: synchronous read returning the inverted address
  always @(posedge clk) mrdata <= (men && mwe == 4'b0000) ? ~maddr : 32'd0;

  typedef struct {
    logic        r0, r1;
    logic [3:0]  w0, w1;
    logic [31:0] a0, a1, d0, d1;
    logic        g0, g1, v0, v1;
    logic [1:0]  st;
  } vec_t;

  vec_t vt[25];

  function automatic vec_t mk(logic r0, logic r1, logic [3:0] w0, logic [3:0] w1,
                              logic [31:0] a0, logic [31:0] a1,
                              logic g0, logic g1, logic v0, logic v1, logic [1:0] st);
    vec_t v;
    v.r0 = r0; v.r1 = r1; v.w0 = w0; v.w1 = w1; v.a0 = a0; v.a1 = a1;
    v.d0 = ~a0; v.d1 = {a1[15:0], a1[15:0]};
    v.g0 = g0; v.g1 = g1; v.v0 = v0; v.v1 = v1; v.st = st;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
  endtask

  // driver tasks
  task automatic drive(input vec_t v);
    req0 = v.r0; req1 = v.r1; we0 = v.w0; we1 = v.w1;
    addr0 = v.a0; addr1 = v.a1; wdata0 = v.d0; wdata1 = v.d1;
  endtask

  task automatic drive_idle();
    req0 = 1'b0; req1 = 1'b0; we0 = 4'h0; we1 = 4'h0;
    addr0 = 32'd0; addr1 = 32'd0; wdata0 = 32'd0; wdata1 = 32'd0;
  endtask

  task automatic check_vec(input int i, input vec_t v);
    logic [32:0] e;
    string       tag;
    tag = $sformatf("v%0d", i);
    chk({tag, " gnt0"}, 32'(gnt0), 32'(v.g0));
    chk({tag, " gnt1"}, 32'(gnt1), 32'(v.g1));
    chk({tag, " men"}, 32'(men), 32'(v.g0 | v.g1));
    chk({tag, " maddr"}, maddr, v.g0 ? v.a0 : (v.g1 ? v.a1 : 32'd0));
    chk({tag, " mwdata"}, mwdata, v.g0 ? v.d0 : (v.g1 ? v.d1 : 32'd0));
    chk({tag, " mwe"}, 32'(mwe), 32'(v.g0 ? v.w0 : (v.g1 ? v.w1 : 4'h0)));
    chk({tag, " rvalid0"}, 32'(rvalid0), 32'(v.v0));
    chk({tag, " rvalid1"}, 32'(rvalid1), 32'(v.v1));
    chk({tag, " state"}, 32'(dbg_state), 32'(v.st));
    // scoreboard: retire the previous read, then record this cycle's read
    if (v.v0 || v.v1) begin
      if (exp_q.size() == 0) begin
        chk({tag, " rsp_queue_nonempty"}, 32'd0, 32'd1);
      end else begin
        e = exp_q.pop_front();
        chk({tag, " rsp_owner"}, 32'(v.v1), 32'(e[32]));
        chk({tag, " rdata"}, e[32] ? rdata1 : rdata0, e[31:0]);
      end
    end
    if (v.g0 && v.w0 == 4'h0) exp_q.push_back({1'b0, ~v.a0});
    if (v.g1 && v.w1 == 4'h0) exp_q.push_back({1'b1, ~v.a1});
  endtask

  initial begin
    vt[0]  = mk(1, 1, 4'h0, 4'h0, 32'h100, 32'h200, 1, 0, 0, 0, S_IDLE);
    vt[1]  = mk(1, 1, 4'h0, 4'h0, 32'h104, 32'h204, 1, 0, 1, 0, S_OWN0);
    vt[2]  = mk(1, 1, 4'h0, 4'h0, 32'h108, 32'h208, 1, 0, 1, 0, S_OWN0);
    vt[3]  = mk(1, 1, 4'h0, 4'h0, 32'h10C, 32'h20C, 1, 0, 1, 0, S_OWN0);
    vt[4]  = mk(1, 1, 4'h0, 4'h0, 32'h110, 32'h210, 0, 1, 1, 0, S_OWN0);
    vt[5]  = mk(1, 1, 4'h0, 4'h0, 32'h114, 32'h214, 0, 1, 0, 1, S_OWN1);
    vt[6]  = mk(1, 1, 4'h0, 4'h0, 32'h118, 32'h218, 0, 1, 0, 1, S_OWN1);
    vt[7]  = mk(1, 1, 4'h0, 4'h0, 32'h11C, 32'h21C, 0, 1, 0, 1, S_OWN1);
    vt[8]  = mk(1, 1, 4'h0, 4'h0, 32'h120, 32'h220, 1, 0, 0, 1, S_OWN1);
    vt[9]  = mk(1, 0, 4'h3, 4'h0, 32'h040, 32'h224, 1, 0, 1, 0, S_OWN0);
    vt[9].d0 = 32'hDEADBEEF;
    vt[10] = mk(0, 1, 4'h0, 4'h0, 32'h130, 32'h230, 0, 1, 0, 0, S_OWN0);
    vt[11] = mk(1, 1, 4'h0, 4'h0, 32'h134, 32'h234, 0, 1, 0, 1, S_OWN1);
    vt[12] = mk(1, 1, 4'h0, 4'h0, 32'h138, 32'h238, 0, 1, 0, 1, S_OWN1);
    vt[13] = mk(1, 1, 4'h0, 4'h0, 32'h13C, 32'h23C, 0, 1, 0, 1, S_OWN1);
    vt[14] = mk(1, 1, 4'h0, 4'h0, 32'h140, 32'h240, 1, 0, 0, 1, S_OWN1);
    vt[15] = mk(0, 0, 4'h0, 4'h0, 32'h144, 32'h244, 0, 0, 1, 0, S_OWN0);
    vt[16] = mk(0, 1, 4'h0, 4'hF, 32'h148, 32'h250, 0, 1, 0, 0, S_IDLE);
    vt[16].d1 = 32'h12345678;
    vt[17] = mk(0, 0, 4'h0, 4'h0, 32'h14C, 32'h254, 0, 0, 0, 0, S_OWN1);
    vt[18] = mk(1, 1, 4'h0, 4'h0, 32'h160, 32'h260, 1, 0, 0, 0, S_IDLE);
    vt[19] = mk(1, 0, 4'h0, 4'h0, 32'h164, 32'h264, 1, 0, 1, 0, S_OWN0);
    vt[20] = mk(1, 0, 4'h0, 4'h0, 32'h168, 32'h268, 1, 0, 1, 0, S_OWN0);
    vt[21] = mk(1, 0, 4'h0, 4'h0, 32'h16C, 32'h26C, 1, 0, 1, 0, S_OWN0);
    vt[22] = mk(1, 0, 4'h0, 4'h0, 32'h170, 32'h270, 1, 0, 1, 0, S_OWN0);
    vt[23] = mk(1, 1, 4'h0, 4'h0, 32'h174, 32'h274, 0, 1, 1, 0, S_OWN0);
    vt[24] = mk(0, 0, 4'h0, 4'h0, 32'h178, 32'h278, 0, 0, 0, 1, S_OWN1);

    // reset held with both requesters active: nothing may be granted
    reset = 1'b0;
    drive(vt[0]);
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst gnt0", 32'(gnt0), 32'd0);
    chk("rst gnt1", 32'(gnt1), 32'd0);
    chk("rst men", 32'(men), 32'd0);
    chk("rst maddr", maddr, 32'd0);
    chk("rst rvalid0", 32'(rvalid0), 32'd0);
    chk("rst rvalid1", 32'(rvalid1), 32'd0);
    chk("rst state", 32'(dbg_state), 32'(S_IDLE));

    @(posedge clk); #1;
    reset = 1'b1;
    for (int i = 0; i < 25; i++) begin
      if (i > 0) begin
        @(posedge clk); #1;
      end
      drive(vt[i]);
      @(negedge clk);
      check_vec(i, vt[i]);
    end
    chk("table rsp_queue_drained", 32'(exp_q.size()), 32'd0);

    // read accepted, then reset asserted before the next edge: response dropped
    @(posedge clk); #1;
    req0 = 1'b1; req1 = 1'b0; we0 = 4'h0; addr0 = 32'h300;
    @(negedge clk);
    chk("pre-rst gnt0", 32'(gnt0), 32'd1);
    reset = 1'b0;
    #1;
    chk("mid-rst gnt0", 32'(gnt0), 32'd0);
    chk("mid-rst men", 32'(men), 32'd0);
    @(posedge clk); #1;
    chk("in-rst rvalid0", 32'(rvalid0), 32'd0);
    reset = 1'b1;
    drive_idle();
    @(negedge clk);
    chk("post-rst rvalid0", 32'(rvalid0), 32'd0);
    chk("post-rst state", 32'(dbg_state), 32'(S_IDLE));

    // tie after reset goes to requester 0 even though 0 owned the bus last
    @(posedge clk); #1;
    req0 = 1'b1; req1 = 1'b1; addr0 = 32'h310; addr1 = 32'h410;
    @(negedge clk);
    chk("tie-after-rst gnt0", 32'(gnt0), 32'd1);
    chk("tie-after-rst gnt1", 32'(gnt1), 32'd0);
    chk("tie-after-rst maddr", maddr, 32'h310);

    // asynchronous clear of a live rvalid and of the state, between edges
    @(posedge clk); #1;
    drive_idle();
    @(negedge clk);
    chk("live rvalid0", 32'(rvalid0), 32'd1);
    chk("live rdata0", rdata0, ~32'h310);
    chk("live state", 32'(dbg_state), 32'(S_OWN0));
    reset = 1'b0;
    #1;
    chk("async rvalid0", 32'(rvalid0), 32'd0);
    chk("async state", 32'(dbg_state), 32'(S_IDLE));
    @(posedge clk); #1;
    reset = 1'b1;
    @(negedge clk);
    chk("final rvalid0", 32'(rvalid0), 32'd0);
    chk("final rvalid1", 32'(rvalid1), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  // exclusivity watch on every clock phase
  always @(negedge clk) begin
    if (gnt0 && gnt1) $display("FAIL both_grants: got gnt0=1 gnt1=1 required at most one at %0t", $time);
  end

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter: MAX_BURST, 4, maximum consecutive granted beats per owner while the other requester waits (legal 1..15).
REQ-002 Port: clk  input  1  sole clock; all state updates on rising edge.
REQ-003 Port: reset  input  1  asynchronous, active-low reset (0 = reset asserted).
REQ-004 Port: req0 / req1  input  1  access request from requester 0 (CPU data port) / requester 1 (loader/debug).
REQ-005 Port: addr0 / addr1  input  32  byte address of requested access.
REQ-006 Port: wdata0 / wdata1  input  32  write data.
REQ-007 Port: we0 / we1  input  4  byte write enables; 4'b0000 = read.
REQ-008 Port: gnt0 / gnt1  output  1  access accepted this cycle.
REQ-009 Port: rvalid0 / rvalid1  output  1  read data valid on rdata0 / rdata1 this cycle.
REQ-010 Port: rdata0 / rdata1  output  32  read data, both driven from mrdata.
REQ-011 Port: men  output  1  memory access strobe.
REQ-012 Port: maddr  output  32  memory byte address.
REQ-013 Port: mwdata  output  32  memory write data.
REQ-014 Port: mwe  output  4  memory byte write enables.
REQ-015 Port: mrdata  input  32  memory read data, valid the cycle after a read strobe (synchronous read).

Function
REQ-016 An access SHALL be accepted exactly in a cycle where reqN=1 and gntN=1; gnt0 and gnt1 SHALL never both be 1.
REQ-017 In an accept cycle men=1 and maddr/mwdata/mwe SHALL equal addrN/wdataN/weN of the granted requester (combinational, same cycle).
REQ-018 With no grant: men=0, maddr=0, mwdata=0, mwe=4'b0000.
REQ-019 gntN SHALL be combinational from state, counter, last_owner, req0, req1; grants only to an asserted request.
REQ-020 FSM states: IDLE, OWN0, OWN1; 4-bit beat counter cnt; 1-bit last_owner.
REQ-021 IDLE: single request -> grant it; both -> grant requester != last_owner; next state OWN<winner>, cnt=1, last_owner=winner; none -> stay IDLE.
REQ-022 OWNx, reqx=1, (cnt<MAX_BURST or other req=0): grant x, cnt=cnt+1 saturating at 15, stay OWNx.
REQ-023 OWNx, reqx=1, cnt>=MAX_BURST, other req=1: grant other, next OWN<other>, cnt=1, last_owner=other.
REQ-024 OWNx, reqx=0, other req=1: grant other same cycle, next OWN<other>, cnt=1, last_owner=other.
REQ-025 OWNx, req0=req1=0: no grant, next IDLE, cnt=0; last_owner unchanged.
REQ-026 rvalidN SHALL be a flop set to 1 the cycle after an accepted read (we=0) by N, else 0; writes never raise rvalid.
REQ-027 Back-to-back reads SHALL yield rvalid on consecutive cycles in issue order; no stalls inserted by the arbiter (one beat per cycle throughput).
REQ-028 Requesters SHALL hold addr/wdata/we stable while req=1 and gnt=0; arbiter does not latch request fields.

Reset
REQ-029 reset=0 SHALL immediately force state=IDLE, cnt=0, last_owner=1, rvalid0=rvalid1=0, independent of clk.
REQ-030 While reset=0, gnt0=gnt1=0 and men=0 regardless of requests.
REQ-031 Reset mid-operation SHALL drop any pending read response (no rvalid after release); first grant after release goes to requester 0 on a tie.
REQ-032 Release of reset SHALL be followed by normal arbitration from the first rising edge with reset=1.

Verification
REQ-033 Reset release, req0=req1=1 reads at 0x100/0x200 -> gnt0=1 cycle 0, maddr=0x100; rvalid0=1 cycle 1 with rdata0=mrdata.
REQ-034 MAX_BURST=4, req0 and req1 held high continuously -> grant pattern 0,0,0,0,1,1,1,1,0,... ; never both grants.
REQ-035 req0 write we0=4'b0011 addr 0x40 data 0xDEADBEEF, req1 idle -> men=1, mwe=4'b0011, mwdata=0xDEADBEEF same cycle; rvalid0 stays 0.
REQ-036 Owner 0 drops req0 while req1=1 -> gnt1=1 in that same cycle, no idle bubble; cnt restarts at 1.
REQ-037 Read accepted cycle N, reset asserted between cycle N and N+1 edge -> rvalid0=0 at N+1 and thereafter until a new read.
REQ-038 Both requests low for one cycle after owner 1 -> state IDLE; next tie grants requester 0 (last_owner=1).
